// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch queue between the fetch and decode stages.
//               Holds up to DEPTH {instruction, PC} entries in strict FIFO
//               order. Registered outputs only: an entry pushed at an edge
//               becomes visible at the head after that edge, never in the
//               same cycle. A flush (taken branch) discards everything.
//
// Parameters  : DEPTH     - number of entries (power of two, >= 2)
//               WORD      - PC width
//               INSTR_LEN - instruction width
//
// Ports       : clk             in   rising-edge clock
//               reset           in   asynchronous active-high reset
//               flush           in   synchronous discard of all entries
//               in_valid        in   fetch presents an entry
//               in_ready        out  queue can accept an entry (not full)
//               in_instruction  in   fetched instruction
//               in_pc           in   PC of the fetched instruction
//               out_valid       out  head entry available (not empty)
//               out_ready       in   decode consumes the head entry
//               out_instruction out  head instruction, 0 when empty
//               out_pc          out  head PC, 0 when empty
//               count           out  number of occupied entries
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int DEPTH     = 4,
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_LEN-1:0]       in_instruction,
  input  logic [WORD-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_LEN-1:0]       out_instruction,
  output logic [WORD-1:0]            out_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  // Storage carries no reset; validity is tracked purely by the pointers.
  logic [INSTR_LEN-1:0] r_instr_mem [DEPTH];
  logic [WORD-1:0]      r_pc_mem    [DEPTH];

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign in_ready  = (r_count != c_FULL);
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  // Flush and reset suppress both handshakes so neither storage nor
  // pointers move in those cycles.
  assign w_push = in_valid  & in_ready  & ~flush & ~reset;
  assign w_pop  = out_ready & out_valid & ~flush & ~reset;

  assign out_instruction = out_valid ? r_instr_mem[r_rd_ptr] : '0;
  assign out_pc          = out_valid ? r_pc_mem[r_rd_ptr]    : '0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= in_instruction;
      r_pc_mem[r_wr_ptr]    <= in_pc;
    end
  end

  // Pointers are exactly c_PTR_W bits, so DEPTH-1 + 1 wraps to 0 naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue. A queue-based reference
//               model tracks the expected contents; a compare process checks
//               every DUT output against it on each falling edge. Directed
//               sequences pin the model with literal expectations, followed
//               by a randomized push/pop/flush phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int DEPTH     = 4;
  localparam int WORD      = 64;
  localparam int INSTR_LEN = 32;

  logic                   clk;
  logic                   reset;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [INSTR_LEN-1:0]   in_instruction;
  logic [WORD-1:0]        in_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_LEN-1:0]   out_instruction;
  logic [WORD-1:0]        out_pc;
  logic [$clog2(DEPTH):0] count;

  fetch_queue #(
    .DEPTH     (DEPTH),
    .WORD      (WORD),
    .INSTR_LEN (INSTR_LEN)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instruction  (in_instruction),
    .in_pc           (in_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [WORD-1:0]      pc;
    logic [INSTR_LEN-1:0] ins;
  } ent_t;

  ent_t q[$];
  bit   m_pop;
  bit   m_push;
  ent_t m_new;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      m_pop  = out_ready && (q.size() > 0);
      m_push = in_valid && (q.size() < DEPTH);
      m_new.pc  = in_pc;
      m_new.ins = in_instruction;
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back(m_new);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("count", 64'(count), 64'(q.size()));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
    check("out_pc", out_pc, (q.size() != 0) ? q[0].pc : 64'h0);
    check("out_instruction", 64'(out_instruction),
          (q.size() != 0) ? 64'(q[0].ins) : 64'h0);
  end

  // Apply inputs for the next rising edge, then return 1 time unit after it.
  task automatic step(input logic v, input logic [WORD-1:0] pc,
                      input logic [INSTR_LEN-1:0] ins, input logic ordy,
                      input logic fl);
    in_valid       = v;
    in_pc          = pc;
    in_instruction = ins;
    out_ready      = ordy;
    flush          = fl;
    @(posedge clk);
    #1;
  endtask

  logic [WORD-1:0] popped;

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_pc = '0;
    in_instruction = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Single push becomes visible after the push edge
    step(1'b1, 64'h0, 32'h8B020020, 1'b0, 1'b0);
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_pc", out_pc, 64'h0);
    check("first_instr", 64'(out_instruction), 64'h8B020020);
    check("first_count", 64'(count), 64'd1);

    // Fill to DEPTH, attempt a fifth push, drain in order
    for (int i = 1; i < 4; i++) step(1'b1, 64'(i * 4), 32'(32'h1000 + i), 1'b0, 1'b0);
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 64'h10, 32'hDEAD, 1'b0, 1'b0);
    check("full_reject_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", out_pc, 64'(i * 4));
      step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    end
    check("drain_count", 64'(count), 64'd0);

    // Steady push and pop at count 2, across pointer wrap
    step(1'b1, 64'h100, 32'h1, 1'b0, 1'b0);
    step(1'b1, 64'h104, 32'h2, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      popped = out_pc;
      step(1'b1, 64'(64'h108 + 4 * k), 32'(k + 3), 1'b1, 1'b0);
      check("stream_pc", popped, 64'(64'h100 + 4 * k));
      check("stream_count", 64'(count), 64'd2);
    end

    // Flush with concurrent push and pop at count 3
    step(1'b1, 64'h300, 32'h33, 1'b0, 1'b0);
    check("preflush_count", 64'(count), 64'd3);
    step(1'b1, 64'h200, 32'h22, 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_pc", out_pc, 64'h0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    step(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    check("flush_absent", 64'(out_valid), 64'd0);

    // Asynchronous reset pulse between edges
    step(1'b1, 64'h500, 32'h55, 1'b0, 1'b0);
    step(1'b1, 64'h504, 32'h56, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_pc", out_pc, 64'h0);
    #1 reset = 1'b0;
    step(1'b1, 64'h40, 32'h44, 1'b0, 1'b0);
    check("post_rst_pc", out_pc, 64'h40);
    check("post_rst_count", 64'(count), 64'd1);
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

    // Push and pop requested together while empty: no bypass
    in_valid = 1'b1;
    in_pc = 64'h600;
    in_instruction = 32'h66;
    out_ready = 1'b1;
    #1;
    check("empty_no_bypass", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("empty_push_valid", 64'(out_valid), 64'd1);
    check("empty_push_pc", out_pc, 64'h600);
    check("empty_push_count", 64'(count), 64'd1);

    // Randomized phase
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) < 7), {$urandom, $urandom}, $urandom,
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 31) == 0));
    end
    step(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
